// File: rtl/hilo_file_if.sv
// HI/LO register-file port bundle: WB commit path, MEM forwarding source,
// architectural read-back, EX forwarded read and commit counter.
interface hilo_file_if #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
);
   logic [WIDTH-1:0]     wb_hi;
   logic [WIDTH-1:0]     wb_lo;
   logic                 wb_whilo;
   logic [WIDTH-1:0]     mem_hi;
   logic [WIDTH-1:0]     mem_lo;
   logic                 mem_whilo;
   logic [WIDTH-1:0]     hi_o;
   logic [WIDTH-1:0]     lo_o;
   logic [WIDTH-1:0]     rd_hi;
   logic [WIDTH-1:0]     rd_lo;
   logic [CNT_WIDTH-1:0] commit_cnt;

   // Pipeline side: presents writes and forwarding sources, consumes reads.
   modport master (
      output wb_hi, wb_lo, wb_whilo, mem_hi, mem_lo, mem_whilo,
      input  hi_o, lo_o, rd_hi, rd_lo, commit_cnt
   );

   // Register-file side.
   modport slave (
      input  wb_hi, wb_lo, wb_whilo, mem_hi, mem_lo, mem_whilo,
      output hi_o, lo_o, rd_hi, rd_lo, commit_cnt
   );
endinterface

// File: rtl/hilo_file.sv
// HI/LO register file: WB writes commit at the edge (1-cycle latency), EX reads are
// forwarded combinationally MEM > WB > state; no backpressure, every write is accepted.
module hilo_file #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input logic          clk,
   input logic          rst,
   hilo_file_if.slave   bus
);
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;
   logic [CNT_WIDTH-1:0] cnt_q;

   // Reset wins over a concurrent write, so a write in the reset cycle is neither stored nor counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
      end else if (bus.wb_whilo) begin
         hi_q  <= bus.wb_hi;
         lo_q  <= bus.wb_lo;
         cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // HI and LO always come from the same source; MEM is the youngest writer.
   always_comb begin
      bus.rd_hi = hi_q;
      bus.rd_lo = lo_q;
      if (rst) begin
         bus.rd_hi = '0;
         bus.rd_lo = '0;
      end else if (bus.mem_whilo) begin
         bus.rd_hi = bus.mem_hi;
         bus.rd_lo = bus.mem_lo;
      end else if (bus.wb_whilo) begin
         bus.rd_hi = bus.wb_hi;
         bus.rd_lo = bus.wb_lo;
      end
   end

   assign bus.hi_o       = hi_q;
   assign bus.lo_o       = lo_q;
   assign bus.commit_cnt = cnt_q;
endmodule

// File: tb/tb_hilo_file.sv
// Directed bench for hilo_file: stimulus queues hand-computed expectations per cycle,
// a negedge monitor pops and compares; a CNT_WIDTH=4 copy shares the stimulus for wrap.
module tb_hilo_file;
   logic clk;
   logic rst;

   hilo_file_if #(.WIDTH(32), .CNT_WIDTH(16)) bus ();
   hilo_file_if #(.WIDTH(32), .CNT_WIDTH(4))  bus4 ();

   hilo_file #(.WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   hilo_file #(.WIDTH(32), .CNT_WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   assign bus4.wb_hi     = bus.wb_hi;
   assign bus4.wb_lo     = bus.wb_lo;
   assign bus4.wb_whilo  = bus.wb_whilo;
   assign bus4.mem_hi    = bus.mem_hi;
   assign bus4.mem_lo    = bus.mem_lo;
   assign bus4.mem_whilo = bus.mem_whilo;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] rdh;
      logic [31:0] rdl;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%08h want 0x%08h", nm, fld, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk(e.name, "hi_o",       bus.hi_o,                e.hi);
         chk(e.name, "lo_o",       bus.lo_o,                e.lo);
         chk(e.name, "rd_hi",      bus.rd_hi,               e.rdh);
         chk(e.name, "rd_lo",      bus.rd_lo,               e.rdl);
         chk(e.name, "commit_cnt", {16'h0, bus.commit_cnt}, {16'h0, e.cnt});
         chk(e.name, "cnt4",       {28'h0, bus4.commit_cnt}, {28'h0, e.cnt4});
      end
   end

   task automatic step(input string nm, input logic r,
                       input logic wbw, input logic [31:0] wh, input logic [31:0] wl,
                       input logic mw, input logic [31:0] mh, input logic [31:0] ml,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic [31:0] erh, input logic [31:0] erl,
                       input logic [15:0] ec, input logic [3:0] ec4);
      exp_t e;
      rst           = r;
      bus.wb_whilo  = wbw;
      bus.wb_hi     = wh;
      bus.wb_lo     = wl;
      bus.mem_whilo = mw;
      bus.mem_hi    = mh;
      bus.mem_lo    = ml;
      e.name = nm; e.hi = eh; e.lo = el; e.rdh = erh; e.rdl = erl; e.cnt = ec; e.cnt4 = ec4;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      bus.wb_whilo  = 1'b1;
      bus.wb_hi     = 32'hFFFF_FFFF;
      bus.wb_lo     = 32'hFFFF_FFFF;
      bus.mem_whilo = 1'b0;
      bus.mem_hi    = '0;
      bus.mem_lo    = '0;
      @(posedge clk);
      #1;

      //    name          rst wbw wb_hi         wb_lo         mw  mem_hi  mem_lo  hi_o          lo_o          rd_hi         rd_lo         cnt  cnt4
      step("rst_hold",    1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
      step("rst_release", 0, 0, 32'h0,        32'h0,        0, 32'h0, 32'h0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
      step("commit_wr",   0, 1, 32'h12345678, 32'h9ABCDEF0, 0, 32'h0, 32'h0, 32'h0,        32'h0,        32'h12345678, 32'h9ABCDEF0, 0, 0);
      step("commit_rd",   0, 0, 32'h0,        32'h0,        0, 32'h0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1, 1);
      step("wr_1_2",      0, 1, 32'h1,        32'h2,        0, 32'h0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h1,        32'h2,        1, 1);
      step("wb_fwd",      0, 1, 32'hA,        32'hB,        0, 32'h0, 32'h0, 32'h1,        32'h2,        32'hA,        32'hB,        2, 2);
      step("wr_7_8",      0, 1, 32'h7,        32'h8,        0, 32'h0, 32'h0, 32'hA,        32'hB,        32'h7,        32'h8,        3, 3);
      step("mem_pri",     0, 1, 32'hA,        32'hB,        1, 32'hC, 32'hD, 32'h7,        32'h8,        32'hC,        32'hD,        4, 4);
      step("mem_only",    0, 0, 32'h0,        32'h0,        1, 32'hE, 32'hF, 32'hA,        32'hB,        32'hE,        32'hF,        5, 5);
      step("post_mem",    0, 0, 32'h0,        32'h0,        0, 32'h0, 32'h0, 32'hA,        32'hB,        32'hA,        32'hB,        5, 5);
      step("alt_wr1",     0, 1, 32'h11,       32'h22,       0, 32'h0, 32'h0, 32'hA,        32'hB,        32'h11,       32'h22,       5, 5);
      step("alt_idle",    0, 0, 32'h0,        32'h0,        0, 32'h0, 32'h0, 32'h11,       32'h22,       32'h11,       32'h22,       6, 6);
      step("alt_wr2",     0, 1, 32'h33,       32'h44,       0, 32'h0, 32'h0, 32'h11,       32'h22,       32'h33,       32'h44,       6, 6);
      step("rst_mid",     1, 1, 32'h55,       32'h66,       1, 32'h77, 32'h88, 32'h33,     32'h44,       32'h0,        32'h0,        7, 7);
      step("after_rst",   0, 0, 32'h0,        32'h0,        0, 32'h0, 32'h0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
      step("rel_wr",      0, 1, 32'h99,       32'hAA,       0, 32'h0, 32'h0, 32'h0,        32'h0,        32'h99,       32'hAA,       0, 0);
      step("rel_rd",      0, 0, 32'h0,        32'h0,        0, 32'h0, 32'h0, 32'h99,       32'hAA,       32'h99,       32'hAA,       1, 1);
      step("wrap_rst",    1, 0, 32'h0,        32'h0,        0, 32'h0, 32'h0, 32'h99,       32'hAA,       32'h0,        32'h0,        1, 1);

      // 17 back-to-back writes: the 4-bit counter walks 0..15, wraps to 0, then 1 after the last.
      for (int i = 0; i < 17; i++) begin
         logic [31:0] ph;
         logic [31:0] pl;
         logic [3:0]  c4;
         ph = (i == 0) ? 32'h0 : 32'h100 + 32'(i - 1);
         pl = (i == 0) ? 32'h0 : 32'h200 + 32'(i - 1);
         c4 = 4'(i);
         step("wrap_wr", 0, 1, 32'h100 + 32'(i), 32'h200 + 32'(i), 0, 32'h0, 32'h0,
              ph, pl, 32'h100 + 32'(i), 32'h200 + 32'(i), 16'(i), c4);
      end
      step("wrap_end",    0, 0, 32'h0,        32'h0,        0, 32'h0, 32'h0, 32'h110,      32'h210,      32'h110,      32'h210,      17, 1);

      for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
